dpll_dco_param: RTL and testbench

//  Parametrised digitally controlled oscillator for the DPLL symbol-clock loop; successor to the fixed 100 kHz DCO.

---
 rtl/dpll_dco_param.sv | 147 ++++++++++++++
 tb/tb_dpll_dco_param.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dpll_dco_param.sv
// Parametrised DCO for the DPLL symbol-clock loop: clamped, steppable, loadable period,
// phase realignment on data edges, rise/mid strobes and a lock indicator.
module dpll_dco_param #(
   parameter int CNT_W      = 10,
   parameter int NOM_PERIOD = 60,
   parameter int MIN_PERIOD = 40,
   parameter int MAX_PERIOD = 80,
   parameter int STEP       = 1,
   parameter int LOCK_N     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             carry_pulse,
   input  logic             sub_pulse,
   input  logic             both_edge,
   input  logic             period_ld,
   input  logic [CNT_W-1:0] period_in,
   output logic             clk_para,
   output logic             tick_rise,
   output logic             tick_mid,
   output logic [CNT_W-1:0] period_cur,
   output logic             at_min,
   output logic             at_max,
   output logic             locked
);

   localparam int LCK_W = $clog2(LOCK_N + 1);

   localparam logic [CNT_W:0]   MIN_W  = (CNT_W + 1)'(MIN_PERIOD);
   localparam logic [CNT_W:0]   MAX_W  = (CNT_W + 1)'(MAX_PERIOD);
   localparam logic [CNT_W:0]   STEP_W = (CNT_W + 1)'(STEP);
   localparam logic [CNT_W-1:0] NOM_P  = CNT_W'(NOM_PERIOD);
   localparam logic [CNT_W-1:0] MIN_P  = CNT_W'(MIN_PERIOD);
   localparam logic [CNT_W-1:0] MAX_P  = CNT_W'(MAX_PERIOD);
   localparam logic [LCK_W-1:0] LOCK_V = LCK_W'(LOCK_N);

   function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W:0] v);
      logic [CNT_W:0] r;
      r = v;
      if (v < MIN_W) r = MIN_W;
      else if (v > MAX_W) r = MAX_W;
      return r[CNT_W-1:0];
   endfunction

   function automatic logic [CNT_W-1:0] step_down(input logic [CNT_W-1:0] p);
      logic [CNT_W:0] r;
      r = {1'b0, p};
      if (r >= MIN_W + STEP_W) r = r - STEP_W;
      else r = MIN_W;
      return r[CNT_W-1:0];
   endfunction

   function automatic logic [CNT_W-1:0] step_up(input logic [CNT_W-1:0] p);
      logic [CNT_W:0] r;
      r = {1'b0, p} + STEP_W;
      if (r > MAX_W) r = MAX_W;
      return r[CNT_W-1:0];
   endfunction

   logic [CNT_W-1:0] count;
   logic [LCK_W-1:0] lock_cnt;
   logic             adj_seen;

   logic [CNT_W-1:0] p_next;
   logic [CNT_W-1:0] half_next;
   logic [CNT_W-1:0] count_next;
   logic             rise_evt;
   logic             mid_evt;
   logic             clk_para_next;
   logic             adjust;
   logic [LCK_W-1:0] lock_cnt_next;
   logic             adj_seen_next;

   // Period update: load wins, opposing pulses cancel, otherwise step with clamping.
   always_comb begin
      p_next = period_cur;
      if (period_ld)
         p_next = clamp_period({1'b0, period_in});
      else if (carry_pulse && !sub_pulse)
         p_next = step_down(period_cur);
      else if (sub_pulse && !carry_pulse)
         p_next = step_up(period_cur);
   end

   // Phase counter compares against the new period so a shrink wraps immediately.
   always_comb begin
      count_next = count;
      if (en) begin
         if (both_edge)
            count_next = '0;
         else if (({1'b0, count} + (CNT_W + 1)'(1)) >= {1'b0, p_next})
            count_next = '0;
         else
            count_next = count + CNT_W'(1);
      end
   end

   assign half_next     = p_next >> 1;
   assign rise_evt      = en && (count_next == '0) && (count != '0);
   assign mid_evt       = en && (count_next == half_next);
   assign clk_para_next = en ? (count_next < half_next) : clk_para;
   assign adjust        = (carry_pulse ^ sub_pulse) | period_ld;

   // A period only counts toward lock if no adjust landed anywhere inside it.
   always_comb begin
      lock_cnt_next = lock_cnt;
      adj_seen_next = adj_seen;
      if (rise_evt) begin
         adj_seen_next = 1'b0;
         if (adj_seen || adjust)
            lock_cnt_next = '0;
         else if (lock_cnt != LOCK_V)
            lock_cnt_next = lock_cnt + LCK_W'(1);
      end else if (adjust) begin
         adj_seen_next = 1'b1;
         lock_cnt_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         period_cur <= NOM_P;
         count      <= '0;
         clk_para   <= 1'b1;
         tick_rise  <= 1'b0;
         tick_mid   <= 1'b0;
         at_min     <= (NOM_P == MIN_P);
         at_max     <= (NOM_P == MAX_P);
         lock_cnt   <= '0;
         adj_seen   <= 1'b0;
         locked     <= 1'b0;
      end else begin
         period_cur <= p_next;
         count      <= count_next;
         clk_para   <= clk_para_next;
         tick_rise  <= rise_evt;
         tick_mid   <= mid_evt;
         at_min     <= (p_next == MIN_P);
         at_max     <= (p_next == MAX_P);
         lock_cnt   <= lock_cnt_next;
         adj_seen   <= adj_seen_next;
         locked     <= (lock_cnt_next == LOCK_V);
      end
   end

endmodule

// File: tb/tb_dpll_dco_param.sv
// Directed self-checking bench for dpll_dco_param with default parameters.
module tb_dpll_dco_param;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       carry_pulse = 1'b0;
   logic       sub_pulse = 1'b0;
   logic       both_edge = 1'b0;
   logic       period_ld = 1'b0;
   logic [9:0] period_in = '0;
   logic       clk_para;
   logic       tick_rise;
   logic       tick_mid;
   logic [9:0] period_cur;
   logic       at_min;
   logic       at_max;
   logic       locked;

   int checks = 0;
   int failures = 0;
   int n_rise, n_mid, n_high;
   int steps_to_lock;
   int exp_p;

   dpll_dco_param dut (
      .clk(clk), .rst_n(rst_n), .en(en), .carry_pulse(carry_pulse), .sub_pulse(sub_pulse),
      .both_edge(both_edge), .period_ld(period_ld), .period_in(period_in),
      .clk_para(clk_para), .tick_rise(tick_rise), .tick_mid(tick_mid),
      .period_cur(period_cur), .at_min(at_min), .at_max(at_max), .locked(locked)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      n_rise = 0; n_mid = 0; n_high = 0;
      for (int i = 0; i < n; i++) begin
         step();
         n_rise += int'(tick_rise);
         n_mid  += int'(tick_mid);
         n_high += int'(clk_para);
      end
   endtask

   initial begin
      step(); step();
      chk("rst_clk_para", 32'(clk_para), 1);
      chk("rst_tick_rise", 32'(tick_rise), 0);
      chk("rst_tick_mid", 32'(tick_mid), 0);
      chk("rst_period", 32'(period_cur), 60);
      chk("rst_locked", 32'(locked), 0);
      chk("rst_at_min", 32'(at_min), 0);
      chk("rst_at_max", 32'(at_max), 0);

      // Free run at the nominal period
      rst_n = 1'b1; en = 1'b1;
      run(29);
      chk("t1_high_cycles", 32'(n_high), 29);
      chk("t1_no_mid_early", 32'(n_mid), 0);
      step();
      chk("t1_clk_low_at_30", 32'(clk_para), 0);
      chk("t1_tick_mid_30", 32'(tick_mid), 1);
      run(30);
      chk("t1_low_half", 32'(n_high), 1);
      chk("t1_first_rise", 32'(tick_rise), 1);
      chk("t1_rise_count", 32'(n_rise), 1);
      run(419);
      chk("t1_rises_2_7", 32'(n_rise), 6);
      chk("t1_not_locked_yet", 32'(locked), 0);
      step();
      chk("t1_rise_8", 32'(tick_rise), 1);
      chk("t1_locked_8", 32'(locked), 1);

      // Realign on data edge, and opposing pulses cancel
      run(17);
      both_edge = 1'b1; step(); both_edge = 1'b0;
      chk("t5_realign_rise", 32'(tick_rise), 1);
      chk("t5_realign_clk", 32'(clk_para), 1);
      both_edge = 1'b1; step(); both_edge = 1'b0;
      chk("t5_edge_at_zero_no_rise", 32'(tick_rise), 0);
      carry_pulse = 1'b1; sub_pulse = 1'b1; step(); carry_pulse = 1'b0; sub_pulse = 1'b0;
      chk("t5_both_pulses_period", 32'(period_cur), 60);
      chk("t5_both_pulses_locked", 32'(locked), 1);

      // Freeze with en=0; period still moves
      run(9);
      en = 1'b0;
      run(5);
      chk("t6_freeze_ticks_a", 32'(n_rise + n_mid), 0);
      carry_pulse = 1'b1; step(); carry_pulse = 1'b0;
      run(14);
      chk("t6_freeze_ticks_b", 32'(n_rise + n_mid), 0);
      chk("t6_freeze_clk_held", 32'(n_high), 14);
      chk("t6_period_59", 32'(period_cur), 59);
      chk("t6_unlocked", 32'(locked), 0);
      en = 1'b1;
      run(48);
      chk("t6_resume_no_rise", 32'(n_rise), 0);
      step();
      chk("t6_resume_rise", 32'(tick_rise), 1);

      // Period shrink below current count wraps at once
      period_ld = 1'b1; period_in = 10'd60; step(); period_ld = 1'b0;
      run(49);
      chk("t4_no_rise_to_50", 32'(n_rise), 0);
      period_ld = 1'b1; period_in = 10'd45; step(); period_ld = 1'b0;
      chk("t4_period_45", 32'(period_cur), 45);
      chk("t4_wrap_rise", 32'(tick_rise), 1);
      run(45);
      chk("t4_period_rises", 32'(n_rise), 1);
      chk("t4_period_mids", 32'(n_mid), 1);
      chk("t4_period_high", 32'(n_high), 22);
      chk("t4_rise_at_45", 32'(tick_rise), 1);

      // Load clamping
      period_ld = 1'b1; period_in = 10'd200; step();
      chk("t3_clamp_max", 32'(period_cur), 80);
      chk("t3_at_max", 32'(at_max), 1);
      period_in = 10'd1; step();
      chk("t3_clamp_min", 32'(period_cur), 40);
      chk("t3_at_min", 32'(at_min), 1);
      chk("t3_not_at_max", 32'(at_max), 0);
      period_in = 10'd60; step(); period_ld = 1'b0;
      chk("t3_reload_60", 32'(period_cur), 60);

      // Carry pulses walk the period down to the floor
      for (int k = 1; k <= 25; k++) begin
         carry_pulse = 1'b1; step(); carry_pulse = 1'b0;
         exp_p = (60 - k < 40) ? 40 : 60 - k;
         chk($sformatf("t2_period_k%0d", k), 32'(period_cur), 32'(exp_p));
         chk($sformatf("t2_locked_k%0d", k), 32'(locked), 0);
         run(99);
      end
      chk("t2_at_min", 32'(at_min), 1);
      both_edge = 1'b1; step(); both_edge = 1'b0;
      run(5);
      carry_pulse = 1'b1; step(); carry_pulse = 1'b0;
      chk("t2_floor_hold", 32'(period_cur), 40);
      chk("t2_pulse_unlocks", 32'(locked), 0);
      n_rise = 0; steps_to_lock = 0;
      while (!locked && steps_to_lock < 1000) begin
         step();
         steps_to_lock++;
         n_rise += int'(tick_rise);
      end
      chk("t2_relock_seen", 32'(locked), 1);
      chk("t2_relock_rises", 32'(n_rise), 9);
      chk("t2_relock_cycles", 32'(steps_to_lock), 354);

      // Reset mid-operation
      run(7);
      rst_n = 1'b0; step();
      chk("t6_rst_period", 32'(period_cur), 60);
      chk("t6_rst_clk", 32'(clk_para), 1);
      chk("t6_rst_ticks", 32'(tick_rise | tick_mid), 0);
      chk("t6_rst_locked", 32'(locked), 0);
      chk("t6_rst_at_min", 32'(at_min), 0);
      chk("t6_rst_at_max", 32'(at_max), 0);
      rst_n = 1'b1; step();
      chk("t6_post_rst_clk", 32'(clk_para), 1);
      chk("t6_post_rst_rise", 32'(tick_rise), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
